// File: rtl/core_mmio_bridge_if.sv
// Core M-stage data port bundle between the core and the MMIO bridge.
// The core drives the address, store strobe and store data; the bridge returns load data.
interface core_mmio_bridge_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_mem_write_M;
  logic [DATA_WIDTH-1:0] i_data_addr_M;
  logic [DATA_WIDTH-1:0] i_write_data_M;
  logic [DATA_WIDTH-1:0] o_read_data_M;

  modport master (
    output i_mem_write_M,
    output i_data_addr_M,
    output i_write_data_M,
    input  o_read_data_M
  );

  modport slave (
    input  i_mem_write_M,
    input  i_data_addr_M,
    input  i_write_data_M,
    output o_read_data_M
  );
endinterface

// File: rtl/core_mmio_bridge.sv
// Zero-wait-state split of core data accesses between dmem and a local MMIO block.
// The MMIO block holds a prescaled 64-bit machine timer with compare IRQ and GPIO.
module core_mmio_bridge #(
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] MMIO_BASE      = 32'h8000_0000,
  parameter int          GPIO_WIDTH     = 8,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  core_mmio_bridge_if.slave     core,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  input  logic [GPIO_WIDTH-1:0] i_gpio_in,
  output logic [GPIO_WIDTH-1:0] o_gpio_out,
  output logic                  o_timer_irq
);

  localparam logic [2:0] R_GPIO_OUT = 3'd0;
  localparam logic [2:0] R_GPIO_IN  = 3'd1;
  localparam logic [2:0] R_MTIME_LO = 3'd2;
  localparam logic [2:0] R_MTIME_HI = 3'd3;
  localparam logic [2:0] R_CMP_LO   = 3'd4;
  localparam logic [2:0] R_CMP_HI   = 3'd5;
  localparam logic [2:0] R_PRESCALE = 3'd6;
  localparam logic [2:0] R_CTRL     = 3'd7;

  logic                      sel_mmio;
  logic                      mmio_we;
  logic [2:0]                idx;
  logic [GPIO_WIDTH-1:0]     gpio_meta;
  logic [GPIO_WIDTH-1:0]     gpio_sync;
  logic [63:0]               mtime;
  logic [63:0]               mtimecmp;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic                      timer_en;
  logic                      irq_en;
  logic                      cmp_hit;
  logic [DATA_WIDTH-1:0]     mmio_rdata;

  assign sel_mmio = core.i_data_addr_M[31:5] == MMIO_BASE[31:5];
  assign idx      = core.i_data_addr_M[4:2];
  assign mmio_we  = core.i_mem_write_M & sel_mmio;
  assign cmp_hit  = mtime >= mtimecmp;

  assign o_dmem_we    = core.i_mem_write_M & ~sel_mmio;
  assign o_dmem_addr  = core.i_data_addr_M;
  assign o_dmem_wdata = core.i_write_data_M;

  assign core.o_read_data_M = sel_mmio ? mmio_rdata : i_dmem_rdata;

  always_comb begin
    mmio_rdata = '0;
    unique case (idx)
      R_GPIO_OUT: mmio_rdata[GPIO_WIDTH-1:0] = o_gpio_out;
      R_GPIO_IN:  mmio_rdata[GPIO_WIDTH-1:0] = gpio_sync;
      R_MTIME_LO: mmio_rdata = mtime[31:0];
      R_MTIME_HI: mmio_rdata = mtime[63:32];
      R_CMP_LO:   mmio_rdata = mtimecmp[31:0];
      R_CMP_HI:   mmio_rdata = mtimecmp[63:32];
      R_PRESCALE: mmio_rdata[PRESCALE_WIDTH-1:0] = prescale;
      R_CTRL:     mmio_rdata[2:0] = {cmp_hit, irq_en, timer_en};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_meta  <= '0;
      gpio_sync  <= '0;
      o_gpio_out <= '0;
    end else begin
      gpio_meta <= i_gpio_in;
      gpio_sync <= gpio_meta;
      if (mmio_we && idx == R_GPIO_OUT)
        o_gpio_out <= core.i_write_data_M[GPIO_WIDTH-1:0];
    end
  end

  // Software writes are placed after the tick so they override it;
  // the untouched mtime half keeps its pre-tick value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      prescale    <= '0;
      presc_cnt   <= '0;
      timer_en    <= 1'b0;
      irq_en      <= 1'b0;
      o_timer_irq <= 1'b0;
    end else begin
      o_timer_irq <= irq_en & cmp_hit;
      if (timer_en) begin
        if (presc_cnt == prescale) begin
          presc_cnt <= '0;
          mtime     <= mtime + 64'd1;
        end else begin
          presc_cnt <= presc_cnt + 1'b1;
        end
      end
      if (mmio_we) begin
        unique case (idx)
          R_GPIO_OUT, R_GPIO_IN: ;
          R_MTIME_LO: mtime <= {mtime[63:32], core.i_write_data_M};
          R_MTIME_HI: mtime <= {core.i_write_data_M, mtime[31:0]};
          R_CMP_LO:   mtimecmp[31:0]  <= core.i_write_data_M;
          R_CMP_HI:   mtimecmp[63:32] <= core.i_write_data_M;
          R_PRESCALE: begin
            prescale  <= core.i_write_data_M[PRESCALE_WIDTH-1:0];
            presc_cnt <= '0;
          end
          R_CTRL: begin
            timer_en <= core.i_write_data_M[0];
            irq_en   <= core.i_write_data_M[1];
          end
        endcase
      end
    end
  end

endmodule
